// File: rtl/fantasy_pkg.sv
// Shared types and constants for the fantasy inversion-mode controller:
// link FSM states, mode encodings, switch bit positions and the per-pixel invert rule.
package fantasy_pkg;

   typedef enum logic [1:0] {
      ST_NOLINK = 2'd0,
      ST_LOCK   = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   localparam logic [1:0] MODE_BLK  = 2'b00;
   localparam logic [1:0] MODE_PASS = 2'b01;
   localparam logic [1:0] MODE_INV  = 2'b10;
   localparam logic [1:0] MODE_BLKN = 2'b11;

   localparam int SW_SRC = 3;
   localparam int SW_BYP = 2;

   function automatic logic px_decide(input logic [1:0] mode, input logic blk);
      logic res;
      case (mode)
         MODE_BLK:  res = blk;
         MODE_PASS: res = 1'b0;
         MODE_INV:  res = 1'b1;
         default:   res = ~blk;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/fantasy_mode_ctrl_sw_debounce.sv
// Two-flop synchronizer plus shared-counter debounce for a switch vector.
// The debounce counter exists only when FANTASY_DEBOUNCE_EN is defined; otherwise the synced value passes straight through.
module sw_debounce #(
   parameter int W          = 4,
   parameter int DEB_CYCLES = 1000000
)(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] stable_o
);

   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;
   logic [W-1:0] stable_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef FANTASY_DEBOUNCE_EN
   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [W-1:0]     cand_q;
   logic [CNT_W-1:0] cnt_q;

   // Any change of the whole vector restarts the stability window.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else if (sync2_q != cand_q) begin
         cand_q <= sync2_q;
         cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_q <= cand_q;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   logic unused_deb;
   assign unused_deb = (DEB_CYCLES > 0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stable_q <= '0;
      end else begin
         stable_q <= sync2_q;
      end
   end
`endif

   assign stable_o = stable_q;

endmodule

// File: rtl/fantasy_mode_ctrl.sv
// Frame-synchronous mode controller: commits debounced switches on vs rising edges, runs the link-lock FSM
// and registers the per-pixel invert decision. Debounce is enabled by defining FANTASY_DEBOUNCE_EN.
module fantasy_mode_ctrl
   import fantasy_pkg::*;
#(
   parameter int DEB_CYCLES     = 1000000,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int LOCK_FRAMES    = 4,
   parameter int FCNT_W         = 16
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [3:0]        sw_i,
   input  logic              vs_i,
   input  logic              blk_x_i,
   output logic [1:0]        mode_o,
   output logic              src_sel_o,
   output logic              bypass_o,
   output logic              px_inv_o,
   output logic              link_ok_o,
   output logic [1:0]        state_o,
   output logic [FCNT_W-1:0] frame_cnt_o
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
   localparam int GOOD_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

   logic [3:0]        stable;
   logic              vs_s1_q, vs_s2_q, vs_prev_q;
   logic [WD_W-1:0]   wd_q;
   logic [GOOD_W-1:0] good_q;
   state_e            state_q;
   logic [1:0]        mode_q;
   logic              src_q, byp_q, px_q, link_q;
   logic [FCNT_W-1:0] fcnt_q;

   logic vs_rise, timeout, src_change;

   sw_debounce #(
      .W          (4),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sw_debounce (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .d_i      (sw_i),
      .stable_o (stable)
   );

   // A frame start always beats the watchdog; a source change always forces relock.
   always_comb begin
      vs_rise    = vs_s2_q & ~vs_prev_q;
      timeout    = (wd_q == WD_MAX) & ~vs_rise;
      src_change = vs_rise & (stable[SW_SRC] != src_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_s1_q   <= 1'b0;
         vs_s2_q   <= 1'b0;
         vs_prev_q <= 1'b0;
         wd_q      <= '0;
         good_q    <= '0;
         state_q   <= ST_NOLINK;
         mode_q    <= 2'b00;
         src_q     <= 1'b0;
         byp_q     <= 1'b0;
         px_q      <= 1'b0;
         link_q    <= 1'b0;
         fcnt_q    <= '0;
      end else begin
         vs_s1_q   <= vs_i;
         vs_s2_q   <= vs_s1_q;
         vs_prev_q <= vs_s2_q;

         if (vs_rise) begin
            wd_q <= '0;
         end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + WD_W'(1);
         end

         if (vs_rise) begin
            mode_q <= stable[1:0];
            src_q  <= stable[SW_SRC];
            byp_q  <= |stable[SW_SRC:SW_BYP];
         end

         px_q <= (state_q == ST_RUN) ? px_decide(mode_q, blk_x_i) : 1'b0;

         // frame_cnt stays zero outside RUN because every exit path clears it.
         if (timeout) begin
            state_q <= ST_NOLINK;
            link_q  <= 1'b0;
            fcnt_q  <= '0;
         end else if (src_change) begin
            state_q <= ST_LOCK;
            good_q  <= '0;
            link_q  <= 1'b0;
            fcnt_q  <= '0;
         end else if (vs_rise) begin
            case (state_q)
               ST_NOLINK: begin
                  state_q <= ST_LOCK;
                  good_q  <= '0;
               end
               ST_LOCK: begin
                  if (good_q == GOOD_LAST) begin
                     state_q <= ST_RUN;
                     link_q  <= 1'b1;
                  end else begin
                     good_q <= good_q + GOOD_W'(1);
                  end
               end
               ST_RUN: begin
                  fcnt_q <= fcnt_q + FCNT_W'(1);
               end
               default: begin
                  state_q <= ST_NOLINK;
                  link_q  <= 1'b0;
                  fcnt_q  <= '0;
               end
            endcase
         end
      end
   end

   assign mode_o      = mode_q;
   assign src_sel_o   = src_q;
   assign bypass_o    = byp_q;
   assign px_inv_o    = px_q;
   assign link_ok_o   = link_q;
   assign state_o     = state_q;
   assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_fantasy_mode_ctrl.sv
// Randomized bench for fantasy_mode_ctrl: a frame-level reference model predicts every output each cycle,
// expectations go into a queue and a negedge monitor pops and compares them.
module tb_fantasy_mode_ctrl;

   localparam int DEB = 4;
   localparam int TMO = 100;
   localparam int LF  = 2;
   localparam int FW  = 16;
`ifdef FANTASY_DEBOUNCE_EN
   localparam int HOLD_NEEDED = DEB + 1;
`else
   localparam int HOLD_NEEDED = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    sw;
   logic          vs;
   logic          blk;
   logic [1:0]    mode_o;
   logic          src_sel_o, bypass_o, px_inv_o, link_ok_o;
   logic [1:0]    state_o;
   logic [FW-1:0] frame_cnt_o;

   always #5 clk = ~clk;

   fantasy_mode_ctrl #(
      .DEB_CYCLES     (DEB),
      .TIMEOUT_CYCLES (TMO),
      .LOCK_FRAMES    (LF),
      .FCNT_W         (FW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sw_i        (sw),
      .vs_i        (vs),
      .blk_x_i     (blk),
      .mode_o      (mode_o),
      .src_sel_o   (src_sel_o),
      .bypass_o    (bypass_o),
      .px_inv_o    (px_inv_o),
      .link_ok_o   (link_ok_o),
      .state_o     (state_o),
      .frame_cnt_o (frame_cnt_o)
   );

   typedef struct packed {
      logic [1:0]    mode;
      logic          src;
      logic          byp;
      logic          px;
      logic          link;
      logic [1:0]    st;
      logic [FW-1:0] fc;
   } out_t;

   out_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   // Reference model: inputs seen two cycles late, switch value accepted once held long enough,
   // frame age since the last detected frame start, and frame counting for lock/run.
   logic [3:0] m_sw_late1, m_sw_late2, m_stable;
   logic       m_vs_late1, m_vs_late2, m_vs_late3;
   int         m_held, m_age, m_state, m_good, m_fcnt;
   logic [1:0] m_mode;
   logic       m_src, m_byp, m_px;

   task automatic model_step(input logic [3:0] s, input logic v, input logic b, input logic r);
      logic rise, tmo, src_chg, n_px;
      out_t e;
      if (r) begin
         m_sw_late1 = '0; m_sw_late2 = '0; m_stable = '0;
         m_vs_late1 = 1'b0; m_vs_late2 = 1'b0; m_vs_late3 = 1'b0;
         m_held = 1; m_age = 0; m_state = 0; m_good = 0; m_fcnt = 0;
         m_mode = 2'b00; m_src = 1'b0; m_byp = 1'b0; m_px = 1'b0;
      end else begin
         rise    = m_vs_late2 && !m_vs_late3;
         tmo     = (m_age >= TMO - 1) && !rise;
         src_chg = rise && (m_stable[3] != m_src);
         n_px    = 1'b0;
         if (m_state == 2) begin
            case (m_mode)
               2'd0: n_px = b;
               2'd1: n_px = 1'b0;
               2'd2: n_px = 1'b1;
               default: n_px = !b;
            endcase
         end
         if (rise) begin
            m_mode = m_stable[1:0];
            m_src  = m_stable[3];
            m_byp  = m_stable[3] | m_stable[2];
         end
         if (tmo) begin
            m_state = 0; m_fcnt = 0;
         end else if (src_chg) begin
            m_state = 1; m_good = 0; m_fcnt = 0;
         end else if (rise) begin
            if (m_state == 0) begin
               m_state = 1; m_good = 0;
            end else if (m_state == 1) begin
               m_good++;
               if (m_good == LF) m_state = 2;
            end else begin
               m_fcnt = (m_fcnt + 1) % (1 << FW);
            end
         end
         m_age = rise ? 0 : m_age + 1;
         if (m_held >= HOLD_NEEDED) m_stable = m_sw_late2;
         m_held = (m_sw_late1 == m_sw_late2) ? m_held + 1 : 1;
         m_sw_late2 = m_sw_late1; m_sw_late1 = s;
         m_vs_late3 = m_vs_late2; m_vs_late2 = m_vs_late1; m_vs_late1 = v;
         m_px = n_px;
      end
      e.mode = m_mode; e.src = m_src; e.byp = m_byp; e.px = m_px;
      e.link = (m_state == 2);
      e.st   = 2'(m_state);
      e.fc   = FW'(m_fcnt);
      exp_q.push_back(e);
   endtask

   task automatic run_cycle(input logic [3:0] s, input logic v, input logic b, input logic r);
      sw = s; vs = v; blk = b; rst = r;
      @(posedge clk);
      model_step(s, v, b, r);
      cyc++;
      #1;
   endtask

   out_t mon_exp, mon_got;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {mode_o, src_sel_o, bypass_o, px_inv_o, link_ok_o, state_o, frame_cnt_o};
         vectors++;
         if (mon_got !== mon_exp) begin
            miscompares++;
            $display("FAIL outputs @cycle %0d: got mode=%b src=%b byp=%b px=%b link=%b st=%0d fc=%0d, want mode=%b src=%b byp=%b px=%b link=%b st=%0d fc=%0d",
                     cyc, mon_got.mode, mon_got.src, mon_got.byp, mon_got.px, mon_got.link, mon_got.st, mon_got.fc,
                     mon_exp.mode, mon_exp.src, mon_exp.byp, mon_exp.px, mon_exp.link, mon_exp.st, mon_exp.fc);
         end
      end
   end

   initial begin
      int         period;
      int         hold;
      logic [3:0] sw_cur;
      logic       src_bit;
      logic       r;
      sw = '0; vs = 1'b0; blk = 1'b0; rst = 1'b1;
      sw_cur = '0; src_bit = 1'b0; hold = 0;

      for (int i = 0; i < 3; i++) begin
         run_cycle(4'h0, i[0], 1'b0, 1'b1);
      end

      for (int f = 0; f < 150; f++) begin
         case ($urandom_range(0, 19))
            0:       period = 101;
            1:       period = 100;
            2:       period = 170;
            default: period = 50;
         endcase
         if ($urandom_range(0, 7) == 0) src_bit = ~src_bit;
         $display("frame %0d: period %0d src %0d model state %0d frames %0d", f, period, src_bit, m_state, m_fcnt);
         for (int c = 0; c < period; c++) begin
            if (hold == 0) begin
               sw_cur[1:0] = 2'($urandom_range(0, 3));
               sw_cur[2]   = 1'($urandom_range(0, 1));
               hold        = $urandom_range(1, 12);
            end
            hold--;
            sw_cur[3] = src_bit;
            r = (f == 60) && (c >= 20) && (c < 23);
            run_cycle(sw_cur, (c < 10), 1'($urandom_range(0, 1)), r);
         end
      end

      repeat (2) @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d queued vectors left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
